piano_tone_gen: RTL
===================

# piano_tone_gen

Upstream audio stage for the piano-keys design. Debounces the four raw pushbuttons and selects one note by fixed priority. Synthesises a square-wave tone for that note and pushes signed samples into the audio codec controller's output FIFO through its `audio_out_allowed` / `write_audio_out` handshake. It also exports the active note index so the top level can drive the HEX displays and the VGA key highlighter.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500_000: stable cycles required before a key change is accepted (10 ms at 50 MHz).
- `AMPLITUDE`, default 32'sd10_000_000: positive sample magnitude; the negative half uses `-AMPLITUDE`.
- `HP_SHIFT`, default 0: right-shift applied to every half-period constant; nonzero only for simulation.

Ports:
- `clk` — in, 1: system clock, 50 MHz (`CLOCK_50`).
- `resetn` — in, 1: reset. One clock; reset is asynchronous and active-low.
- `key_n` — in, 4: raw pushbuttons, active-low, asynchronous to `clk`.
- `audio_out_allowed` — in, 1: the codec controller can accept a sample this cycle.
- `write_audio_out` — out, 1: one-cycle sample write strobe.
- `left_sample` — out, 32: signed sample, left channel.
- `right_sample` — out, 32: signed sample, right channel; always equal to `left_sample`.
- `key_down` — out, 4: debounced key state, 1 = pressed.
- `note_valid` — out, 1: a note is sounding.
- `note_idx` — out, 2: active note, 0=C4, 1=D4, 2=E4, 3=F4.

## Operation
- **Synchroniser:** each `key_n` bit passes through 2 flops, then is inverted to pressed=1.
- **Debounce, per key:**
  - A counter clears whenever the synchronised value equals `key_down[i]`.
  - Otherwise it increments each cycle.
  - When it reaches `DEBOUNCE_CYCLES-1`, `key_down[i]` takes the new value and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `key_down`.
- **Note select (registered):**
  - `note_valid = |key_down`.
  - `note_idx` is the lowest set index of `key_down`; it holds its last value when `note_valid`=0.
- **Tone generator:**
  - 17-bit half-period counter `hp_cnt` and a level bit `lvl`.
  - Half-period constants: C4 95_556, D4 85_131, E4 75_843, F4 71_586, each `>> HP_SHIFT`.
  - When `hp_cnt` reaches the half-period minus 1: `lvl` toggles and `hp_cnt` returns to 0. Otherwise `hp_cnt` increments.
  - When `note_idx` or `note_valid` changes: `hp_cnt` returns to 0 and `lvl` goes to 1, so every new note starts on its positive half.
  - Current sample value: `note_valid` ? (`lvl` ? `AMPLITUDE` : `-AMPLITUDE`) : 0.
- **Write FSM (states IDLE, WRITE):**
  - IDLE → WRITE when `audio_out_allowed`=1. On that edge the current sample value is latched into `left_sample`/`right_sample`.
  - WRITE → IDLE unconditionally. `write_audio_out`=1 only in WRITE.
  - The controller therefore sees at most one write per 2 cycles, and the sample is stable for the whole strobe.
  - Silence is still written, as zeros, so the FIFO never starves.

## Timing
- **Reset values:**
  - `write_audio_out`=0, samples=0, `key_down`=0, `note_valid`=0, `note_idx`=0.
  - FSM in IDLE; debounce counters, `hp_cnt` and `lvl` all 0.
- **Key latency:** a `key_n` edge held stable updates `key_down` 2 + `DEBOUNCE_CYCLES` cycles later. `note_valid`/`note_idx` follow 1 cycle after that.
- **Write latency:** `write_audio_out` rises 1 cycle after `audio_out_allowed` is sampled high in IDLE. If `audio_out_allowed` drops while in WRITE, the write still completes; the controller must tolerate this, and the Altera UP core does.
- **Simultaneous presses:** lowest index wins. Releasing the winner switches to the next-lowest held key with a phase restart.
- **Note change during WRITE:** the latched sample is unaffected; the next write carries the new tone.
- **Mid-operation reset:** all state clears asynchronously, the strobe drops immediately, and the FSM reenters IDLE.

## Structure
- Shared package `piano_pkg`:
  - `note_t` enum (C4..F4).
  - Half-period constant array `NOTE_HALF_PERIOD[4]`.
  - `SAMPLE_W` = 32.
- The HEX and VGA consumers reuse `note_t`.
- One sub-module, `key_debounce`: a single-bit synchroniser plus debounce counter, instantiated ×4.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `HP_SHIFT`=10 (C4 half-period 93), and `audio_out_allowed` tied to 1 unless stated.
- **Reset:** assert `resetn`=0 mid-tone → all outputs 0 in the same cycle, `write_audio_out`=0. Release → first strobe 1 cycle after the first allowed sample, then one strobe every 2 cycles.
- **Single note:** `key_n`=4'b1110 held → `key_down`=0001 after 6 cycles, `note_idx`=0, `note_valid`=1. Samples read +10_000_000 for 93 cycles, then -10_000_000.
- **Bounce:** `key_n[1]` pulsed low for 3 cycles → `key_down` stays 0 and samples stay 0.
- **Priority:** hold keys 2 and 3, then add key 1 → `note_idx` 2 → 1 with a phase restart (`lvl`=1). Release key 1 → `note_idx`=2.
- **Backpressure:** `audio_out_allowed`=0 for 50 cycles → no strobes. Raise it → a strobe 1 cycle later carrying the current level.
- **Release:** all keys released → `note_valid`=0, `note_idx` holds, zero samples keep being written.

Source files
------------

// File: rtl/piano_pkg.sv
// Shared definitions for the piano-keys audio path, HEX and VGA consumers.
package piano_pkg;

  localparam int unsigned SAMPLE_W = 32;
  localparam int unsigned HP_W     = 17;
  localparam int unsigned NUM_KEYS = 4;

  typedef enum logic [1:0] {
    NOTE_C4 = 2'd0,
    NOTE_D4 = 2'd1,
    NOTE_E4 = 2'd2,
    NOTE_F4 = 2'd3
  } note_t;

  // Half-period of each note in 50 MHz clock cycles.
  localparam logic [HP_W-1:0] NOTE_HALF_PERIOD [NUM_KEYS] = '{
    17'd95_556, 17'd85_131, 17'd75_843, 17'd71_586
  };

  // Fixed priority: the lowest pressed key index wins.
  function automatic note_t lowest_note(input logic [NUM_KEYS-1:0] keys);
    note_t n;
    n = NOTE_C4;
    if (keys[0])      n = NOTE_C4;
    else if (keys[1]) n = NOTE_D4;
    else if (keys[2]) n = NOTE_E4;
    else              n = NOTE_F4;
    return n;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser and stability counter for one active-low pushbutton.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n,
  output logic key_down
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt;
  logic             pressed_c;

  assign pressed_c = ~sync_q[1];

  // Synchroniser resets to the released level so no spurious press is debounced.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], key_n};
  end

  // Accept a new level only after it disagrees with key_down for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt      <= '0;
      key_down <= 1'b0;
    end else if (pressed_c == key_down) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt      <= '0;
      key_down <= pressed_c;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/piano_tone_gen.sv
// Debounced key priority select, square-wave tone synthesis and codec sample writer.
module piano_tone_gen
  import piano_pkg::*;
#(
  parameter int unsigned        DEBOUNCE_CYCLES = 500_000,
  parameter logic signed [31:0] AMPLITUDE       = 32'sd10_000_000,
  parameter int unsigned        HP_SHIFT        = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  key_n,
  input  logic        audio_out_allowed,
  output logic        write_audio_out,
  output logic [31:0] left_sample,
  output logic [31:0] right_sample,
  output logic [3:0]  key_down,
  output logic        note_valid,
  output logic [1:0]  note_idx
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wr_state_t;

  note_t                       note_q;
  note_t                       note_c;
  logic                        note_valid_c;
  logic                        note_change_c;
  logic [HP_W-1:0]             hp_cnt;
  logic [HP_W-1:0]             half_c;
  logic [HP_W-1:0]             last_c;
  logic                        lvl;
  logic signed [SAMPLE_W-1:0]  sample_c;
  logic        [SAMPLE_W-1:0]  sample_q;
  wr_state_t                   state;
  wr_state_t                   state_next;
  logic                        latch_c;

  // One debouncer per pushbutton.
  for (genvar i = 0; i < int'(NUM_KEYS); i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk     (clk),
      .resetn  (resetn),
      .key_n   (key_n[i]),
      .key_down(key_down[i])
    );
  end

  // Next note; the index holds while nothing is pressed.
  always_comb begin
    note_valid_c  = |key_down;
    note_c        = note_valid_c ? lowest_note(key_down) : note_q;
    note_change_c = (note_valid_c != note_valid) || (note_c != note_q);
  end

  // Registered note select.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      note_valid <= 1'b0;
      note_q     <= NOTE_C4;
    end else begin
      note_valid <= note_valid_c;
      note_q     <= note_c;
    end
  end

  assign note_idx = note_q;

  // Half-period of the active note, scaled down for simulation builds.
  always_comb begin
    half_c = NOTE_HALF_PERIOD[note_q] >> HP_SHIFT;
    last_c = half_c - HP_W'(1);
  end

  // Square-wave phase; any note change restarts on the positive half.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hp_cnt <= '0;
      lvl    <= 1'b0;
    end else if (note_change_c) begin
      hp_cnt <= '0;
      lvl    <= 1'b1;
    end else if (hp_cnt == last_c) begin
      hp_cnt <= '0;
      lvl    <= ~lvl;
    end else begin
      hp_cnt <= hp_cnt + HP_W'(1);
    end
  end

  // Current sample; silence is a real zero sample.
  always_comb begin
    sample_c = '0;
    if (note_valid) sample_c = lvl ? AMPLITUDE : -AMPLITUDE;
  end

  // Write FSM state register plus registered strobe and sample.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      write_audio_out <= 1'b0;
      sample_q        <= '0;
    end else begin
      state           <= state_next;
      write_audio_out <= (state_next == WRITE);
      if (latch_c) sample_q <= sample_c;
    end
  end

  // Write FSM next state: one write, then one idle cycle.
  always_comb begin
    state_next = state;
    latch_c    = 1'b0;
    case (state)
      IDLE: begin
        if (audio_out_allowed) begin
          state_next = WRITE;
          latch_c    = 1'b1;
        end
      end
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign left_sample  = sample_q;
  assign right_sample = sample_q;

endmodule
